sipo_framed: RTL and testbench

Framed serial-in parallel-out shift register with selectable bit order, a bit counter that assembles complete words, and a single-entry valid/ready output stage. It sits between a bit-serial receiver (SPI-style or line decoder) and word-oriented logic, replacing free-running SIPO plus external latch strobe with self-timed word delivery and overrun detection.

---
 rtl/sipo_framed.sv | 89 ++++++++
 tb/tb_sipo_framed.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/sipo_framed.sv
// Framed serial-in parallel-out shift register with a bit counter for word assembly,
// frame resynchronisation, and a single-entry valid/ready output slot with overrun pulse.
module sipo_framed #(
  parameter int OUTPUT_WIDTH = 8,
  parameter bit MSB_FIRST    = 1'b0
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            serial_in,
  input  logic                            serial_valid,
  input  logic                            frame_sync,
  output logic [OUTPUT_WIDTH-1:0]         data,
  output logic                            data_valid,
  input  logic                            data_ready,
  output logic [$clog2(OUTPUT_WIDTH)-1:0] bit_count,
  output logic                            overrun
);

  localparam int CNT_W = $clog2(OUTPUT_WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(OUTPUT_WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [OUTPUT_WIDTH-1:0] shift_q, shift_d;
  logic [OUTPUT_WIDTH-1:0] data_q, data_d;
  logic                    valid_q, valid_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    ovr_q, ovr_d;

  logic [OUTPUT_WIDTH-1:0] base_sr;
  logic [CNT_W-1:0]        base_cnt;
  logic                    complete;
  logic                    slot_free;

  // MSB-first shifts left (new bit at LSB); LSB-first shifts right (new bit at MSB).
  function automatic logic [OUTPUT_WIDTH-1:0] shift_in(input logic [OUTPUT_WIDTH-1:0] cur,
                                                       input logic                    b);
    if (MSB_FIRST)
      return {cur[OUTPUT_WIDTH-2:0], b};
    else
      return {b, cur[OUTPUT_WIDTH-1:1]};
  endfunction

  always_comb begin
    // frame_sync restarts from an empty word; a same-cycle bit becomes bit 0.
    base_sr   = frame_sync ? '0 : shift_q;
    base_cnt  = frame_sync ? '0 : cnt_q;
    complete  = serial_valid && !frame_sync && (cnt_q == LAST_BIT);
    slot_free = !valid_q || data_ready;

    shift_d = serial_valid ? shift_in(base_sr, serial_in) : base_sr;
    cnt_d   = base_cnt;
    if (serial_valid)
      cnt_d = complete ? '0 : base_cnt + CNT_ONE;

    data_d  = data_q;
    valid_d = valid_q;
    ovr_d   = 1'b0;
    if (complete && slot_free) begin
      data_d  = shift_in(shift_q, serial_in);
      valid_d = 1'b1;
    end else if (complete) begin
      ovr_d = 1'b1;
    end else if (valid_q && data_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
      ovr_q   <= 1'b0;
    end else begin
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
      ovr_q   <= ovr_d;
    end
  end

  assign data       = data_q;
  assign data_valid = valid_q;
  assign bit_count  = cnt_q;
  assign overrun    = ovr_q;

endmodule

// File: tb/tb_sipo_framed.sv
// Directed bench for sipo_framed: one LSB-first and one MSB-first instance on shared inputs.
module tb_sipo_framed;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       serial_in = 1'b0;
  logic       serial_valid = 1'b0;
  logic       frame_sync = 1'b0;
  logic       data_ready = 1'b0;

  logic [7:0] data_l, data_m;
  logic       dv_l, dv_m, ov_l, ov_m;
  logic [2:0] bc_l, bc_m;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sipo_framed #(.OUTPUT_WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .reset(reset), .serial_in(serial_in), .serial_valid(serial_valid),
    .frame_sync(frame_sync), .data(data_l), .data_valid(dv_l), .data_ready(data_ready),
    .bit_count(bc_l), .overrun(ov_l));

  sipo_framed #(.OUTPUT_WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .reset(reset), .serial_in(serial_in), .serial_valid(serial_valid),
    .frame_sync(frame_sync), .data(data_m), .data_valid(dv_m), .data_ready(data_ready),
    .bit_count(bc_m), .overrun(ov_m));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Streams w[0] first, so the LSB-first instance assembles w.
  task automatic send_lsb(input logic [7:0] w);
    for (int i = 0; i < 8; i++) begin
      serial_in    = w[i];
      serial_valid = 1'b1;
      tick();
    end
    serial_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    n_checks++; if (data_l !== 8'h00) begin n_fail++; $display("FAIL reset_data_l: got %h expected 00", data_l); end
    n_checks++; if (dv_l !== 1'b0) begin n_fail++; $display("FAIL reset_dv_l: got %b expected 0", dv_l); end
    n_checks++; if (bc_l !== 3'd0) begin n_fail++; $display("FAIL reset_bc_l: got %0d expected 0", bc_l); end
    n_checks++; if (ov_l !== 1'b0) begin n_fail++; $display("FAIL reset_ov_l: got %b expected 0", ov_l); end
    n_checks++; if (data_m !== 8'h00) begin n_fail++; $display("FAIL reset_data_m: got %h expected 00", data_m); end
    reset = 1'b0;
  endtask

  task automatic test_lsb_first();
    logic [7:0] stream;
    stream = 8'b1010_0101;  // stream[7] is sent first
    data_ready = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      serial_in    = stream[i];
      serial_valid = 1'b1;
      tick();
      if (i == 1) begin
        n_checks++; if (bc_l !== 3'd7) begin n_fail++; $display("FAIL lsb_bc7: got %0d expected 7", bc_l); end
        n_checks++; if (dv_l !== 1'b0) begin n_fail++; $display("FAIL lsb_dv_early: got %b expected 0", dv_l); end
      end
    end
    serial_valid = 1'b0;
    n_checks++; if (data_l !== 8'hA5) begin n_fail++; $display("FAIL lsb_data: got %h expected a5", data_l); end
    n_checks++; if (dv_l !== 1'b1) begin n_fail++; $display("FAIL lsb_dv: got %b expected 1", dv_l); end
    n_checks++; if (bc_l !== 3'd0) begin n_fail++; $display("FAIL lsb_bc_wrap: got %0d expected 0", bc_l); end
    n_checks++; if (data_m !== 8'hA5) begin n_fail++; $display("FAIL msb_data_a5: got %h expected a5", data_m); end
    tick();
    n_checks++; if (dv_l !== 1'b0) begin n_fail++; $display("FAIL lsb_accept_dv: got %b expected 0", dv_l); end
    n_checks++; if (data_l !== 8'hA5) begin n_fail++; $display("FAIL lsb_accept_hold: got %h expected a5", data_l); end
  endtask

  task automatic test_msb_first();
    logic [7:0] stream;
    stream = 8'b1100_0000;
    data_ready = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      serial_in    = stream[i];
      serial_valid = 1'b1;
      tick();
    end
    serial_valid = 1'b0;
    n_checks++; if (data_m !== 8'hC0) begin n_fail++; $display("FAIL msb_data_c0: got %h expected c0", data_m); end
    n_checks++; if (dv_m !== 1'b1) begin n_fail++; $display("FAIL msb_dv: got %b expected 1", dv_m); end
    n_checks++; if (data_l !== 8'h03) begin n_fail++; $display("FAIL lsb_data_03: got %h expected 03", data_l); end
    tick();
  endtask

  task automatic test_backpressure();
    data_ready = 1'b0;
    send_lsb(8'h11);
    n_checks++; if (data_l !== 8'h11) begin n_fail++; $display("FAIL bp_first: got %h expected 11", data_l); end
    tick();
    send_lsb(8'h22);
    n_checks++; if (ov_l !== 1'b1) begin n_fail++; $display("FAIL bp_overrun: got %b expected 1", ov_l); end
    n_checks++; if (data_l !== 8'h11) begin n_fail++; $display("FAIL bp_hold: got %h expected 11", data_l); end
    n_checks++; if (dv_l !== 1'b1) begin n_fail++; $display("FAIL bp_dv: got %b expected 1", dv_l); end
    tick();
    n_checks++; if (ov_l !== 1'b0) begin n_fail++; $display("FAIL bp_ov_pulse: got %b expected 0", ov_l); end
    data_ready = 1'b1;
    tick();
    n_checks++; if (dv_l !== 1'b0) begin n_fail++; $display("FAIL bp_release: got %b expected 0", dv_l); end
    n_checks++; if (data_l !== 8'h11) begin n_fail++; $display("FAIL bp_release_data: got %h expected 11", data_l); end
  endtask

  task automatic test_simultaneous();
    logic [7:0] w;
    w = 8'h22;
    data_ready = 1'b0;
    send_lsb(8'h11);
    for (int i = 0; i < 8; i++) begin
      if (i == 7) data_ready = 1'b1;
      serial_in    = w[i];
      serial_valid = 1'b1;
      tick();
    end
    serial_valid = 1'b0;
    n_checks++; if (data_l !== 8'h22) begin n_fail++; $display("FAIL sim_data: got %h expected 22", data_l); end
    n_checks++; if (dv_l !== 1'b1) begin n_fail++; $display("FAIL sim_dv: got %b expected 1", dv_l); end
    n_checks++; if (ov_l !== 1'b0) begin n_fail++; $display("FAIL sim_ov: got %b expected 0", ov_l); end
    tick();
    n_checks++; if (dv_l !== 1'b0) begin n_fail++; $display("FAIL sim_drain: got %b expected 0", dv_l); end
  endtask

  task automatic test_frame_sync();
    logic [7:0] w;
    w = 8'h3C;
    data_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      serial_in    = 1'b1;
      serial_valid = 1'b1;
      tick();
    end
    n_checks++; if (bc_l !== 3'd3) begin n_fail++; $display("FAIL fs_bc3: got %0d expected 3", bc_l); end
    serial_in  = w[0];
    frame_sync = 1'b1;
    tick();
    frame_sync = 1'b0;
    n_checks++; if (bc_l !== 3'd1) begin n_fail++; $display("FAIL fs_bc1: got %0d expected 1", bc_l); end
    for (int i = 1; i < 8; i++) begin
      serial_in = w[i];
      tick();
      if (i == 4) begin
        n_checks++; if (dv_l !== 1'b0) begin n_fail++; $display("FAIL fs_spurious: got %b expected 0", dv_l); end
      end
    end
    serial_valid = 1'b0;
    n_checks++; if (data_l !== 8'h3C) begin n_fail++; $display("FAIL fs_data_l: got %h expected 3c", data_l); end
    n_checks++; if (data_m !== 8'h3C) begin n_fail++; $display("FAIL fs_data_m: got %h expected 3c", data_m); end
    n_checks++; if (dv_l !== 1'b1) begin n_fail++; $display("FAIL fs_dv: got %b expected 1", dv_l); end
    tick();
  endtask

  task automatic test_sync_vs_complete();
    data_ready = 1'b1;
    serial_in  = 1'b1;
    for (int i = 0; i < 7; i++) begin
      serial_valid = 1'b1;
      tick();
    end
    frame_sync = 1'b1;
    tick();
    frame_sync = 1'b0;
    n_checks++; if (bc_l !== 3'd1) begin n_fail++; $display("FAIL svc_bc: got %0d expected 1", bc_l); end
    n_checks++; if (dv_l !== 1'b0) begin n_fail++; $display("FAIL svc_dv: got %b expected 0", dv_l); end
    n_checks++; if (ov_l !== 1'b0) begin n_fail++; $display("FAIL svc_ov: got %b expected 0", ov_l); end
    for (int i = 0; i < 7; i++) tick();
    serial_valid = 1'b0;
    n_checks++; if (data_l !== 8'hFF) begin n_fail++; $display("FAIL svc_data: got %h expected ff", data_l); end
    tick();
  endtask

  task automatic test_reset_mid();
    data_ready = 1'b0;
    send_lsb(8'h11);
    serial_in = 1'b1;
    for (int i = 0; i < 5; i++) begin
      serial_valid = 1'b1;
      tick();
    end
    serial_valid = 1'b0;
    n_checks++; if (bc_l !== 3'd5) begin n_fail++; $display("FAIL rm_bc5: got %0d expected 5", bc_l); end
    #2;
    reset = 1'b1;
    #1;
    n_checks++; if (data_l !== 8'h00) begin n_fail++; $display("FAIL rm_data: got %h expected 00", data_l); end
    n_checks++; if (dv_l !== 1'b0) begin n_fail++; $display("FAIL rm_dv: got %b expected 0", dv_l); end
    n_checks++; if (bc_l !== 3'd0) begin n_fail++; $display("FAIL rm_bc: got %0d expected 0", bc_l); end
    n_checks++; if (ov_l !== 1'b0) begin n_fail++; $display("FAIL rm_ov: got %b expected 0", ov_l); end
    reset = 1'b0;
    data_ready = 1'b1;
    send_lsb(8'h5A);
    n_checks++; if (data_l !== 8'h5A) begin n_fail++; $display("FAIL rm_after: got %h expected 5a", data_l); end
    n_checks++; if (dv_l !== 1'b1) begin n_fail++; $display("FAIL rm_after_dv: got %b expected 1", dv_l); end
    n_checks++; if (ov_l !== 1'b0) begin n_fail++; $display("FAIL rm_after_ov: got %b expected 0", ov_l); end
    tick();
  endtask

  initial begin
    test_reset();
    test_lsb_first();
    test_msb_first();
    test_backpressure();
    test_simultaneous();
    test_frame_sync();
    test_sync_vs_complete();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
